// File: rtl/rf_wb_queue.sv
// Register-file writeback queue: merges load (mem) and ALU (ex) writebacks into one
// in-order FIFO that drains through a single RF write port, with a youngest-match bypass.
module rf_wb_queue #(
   parameter int DEPTH = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      hold,
   input  logic                      mem_valid,
   output logic                      mem_ready,
   input  logic [4:0]                mem_addr,
   input  logic [31:0]               mem_data,
   input  logic                      ex_valid,
   output logic                      ex_ready,
   input  logic [4:0]                ex_addr,
   input  logic [31:0]               ex_data,
   output logic                      RFWr,
   output logic [4:0]                A3,
   output logic [31:0]               WD,
   input  logic [4:0]                q1_addr,
   input  logic [4:0]                q2_addr,
   output logic                      q1_hit,
   output logic                      q2_hit,
   output logic [31:0]               q1_data,
   output logic [31:0]               q2_data,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [4:0]    addr_q [DEPTH];
   logic [31:0]   data_q [DEPTH];

   logic          nonempty, mem_acc, push_mem, push_ex, pop;
   logic [CW:0]   ex_need;

   assign nonempty = (cnt_q != '0);
   assign mem_ready = rst && !flush && (cnt_q < CW'(DEPTH));
   assign mem_acc   = mem_valid && mem_ready;
   // ex needs one slot beyond whatever mem takes this same edge
   assign ex_need   = {1'b0, cnt_q} + (CW+1)'(1) + {{CW{1'b0}}, mem_acc};
   assign ex_ready  = rst && !flush && (ex_need <= (CW+1)'(DEPTH));

   assign push_mem = mem_acc && (mem_addr != '0);
   assign push_ex  = ex_valid && ex_ready && (ex_addr != '0);

   assign RFWr  = nonempty && !hold;
   assign A3    = nonempty ? addr_q[rd_q] : '0;
   assign WD    = nonempty ? data_q[rd_q] : '0;
   assign pop   = RFWr && !flush;
   assign count = cnt_q;

   always_comb begin
      rd_d  = rd_q + PW'(pop);
      wr_d  = wr_q + PW'(push_mem) + PW'(push_ex);
      cnt_d = cnt_q + CW'(push_mem) + CW'(push_ex) - CW'(pop);
      if (flush) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
         if (push_mem) begin
            addr_q[wr_q] <= mem_addr;
            data_q[wr_q] <= mem_data;
         end
         if (push_ex) begin
            addr_q[wr_q + PW'(push_mem)] <= ex_addr;
            data_q[wr_q + PW'(push_mem)] <= ex_data;
         end
      end
   end

   // Scan oldest to youngest so the last match wins.
   function automatic logic [32:0] lookup(input logic [4:0] a);
      logic [32:0] r;
      r = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (a != '0 && CW'(i) < cnt_q && addr_q[rd_q + PW'(i)] == a)
            r = {1'b1, data_q[rd_q + PW'(i)]};
      end
      return r;
   endfunction

   always_comb begin
      {q1_hit, q1_data} = lookup(q1_addr);
      {q2_hit, q2_data} = lookup(q2_addr);
   end

endmodule

// File: tb/tb_rf_wb_queue.sv
// Bench for rf_wb_queue: directed scenarios plus random traffic against a queue-based
// model of pending writebacks.
module tb_rf_wb_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst, flush, hold;
   logic        mem_valid, mem_ready, ex_valid, ex_ready;
   logic [4:0]  mem_addr, ex_addr, A3, q1_addr, q2_addr;
   logic [31:0] mem_data, ex_data, WD, q1_data, q2_data;
   logic        RFWr, q1_hit, q2_hit;
   logic [$clog2(DEPTH):0] count;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t mq[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   rf_wb_queue #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .flush(flush), .hold(hold),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_addr(ex_addr), .ex_data(ex_data),
      .RFWr(RFWr), .A3(A3), .WD(WD),
      .q1_addr(q1_addr), .q2_addr(q2_addr),
      .q1_hit(q1_hit), .q2_hit(q2_hit), .q1_data(q1_data), .q2_data(q2_data),
      .count(count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, compare against the model, clock, update the model.
   task automatic step(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                       input logic fl, input logic hd,
                       input logic [4:0] a1, input logic [4:0] a2);
      logic emr, eer, ewr, h1, h2;
      logic [4:0]  ea3;
      logic [31:0] ewd, d1, d2;
      int          n;
      mem_valid = mv; mem_addr = ma; mem_data = md;
      ex_valid = ev; ex_addr = ea; ex_data = ed;
      flush = fl; hold = hd; q1_addr = a1; q2_addr = a2;
      #1;
      n   = mq.size();
      emr = !fl && n < DEPTH;
      eer = !fl && (DEPTH - n) >= (1 + ((mv && emr) ? 1 : 0));
      ewr = n > 0 && !hd;
      ea3 = (n > 0) ? mq[0].a : 5'd0;
      ewd = (n > 0) ? mq[0].d : 32'd0;
      h1 = 1'b0; d1 = '0; h2 = 1'b0; d2 = '0;
      foreach (mq[i]) begin
         if (a1 != 0 && mq[i].a == a1) begin h1 = 1'b1; d1 = mq[i].d; end
         if (a2 != 0 && mq[i].a == a2) begin h2 = 1'b1; d2 = mq[i].d; end
      end
      check("mem_ready", 32'(mem_ready), 32'(emr));
      check("ex_ready",  32'(ex_ready),  32'(eer));
      check("RFWr",      32'(RFWr),      32'(ewr));
      check("A3",        32'(A3),        32'(ea3));
      check("WD",        WD,             ewd);
      check("count",     32'(count),     32'(n));
      check("q1_hit",    32'(q1_hit),    32'(h1));
      check("q1_data",   q1_data,        d1);
      check("q2_hit",    32'(q2_hit),    32'(h2));
      check("q2_data",   q2_data,        d2);
      @(posedge clk);
      if (fl) mq.delete();
      else begin
         if (ewr) void'(mq.pop_front());
         if (mv && emr && ma != 0) mq.push_back('{a: ma, d: md});
         if (ev && eer && ea != 0) mq.push_back('{a: ea, d: ed});
      end
      @(negedge clk);
   endtask

   task automatic idle(input logic hd);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, hd, 5'd0, 5'd0);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_count"}, 32'(count), 32'd0);
      check({tag, "_RFWr"},  32'(RFWr),  32'd0);
      check({tag, "_A3"},    32'(A3),    32'd0);
      check({tag, "_WD"},    WD,         32'd0);
      check({tag, "_hit"},   32'({q1_hit, q2_hit}), 32'd0);
      check({tag, "_data"},  q1_data | q2_data, 32'd0);
      check({tag, "_rdy"},   32'({mem_ready, ex_ready}), 32'd0);
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; hold = 1'b0;
      mem_valid = 1'b1; mem_addr = 5'd7; mem_data = 32'h1;
      ex_valid = 1'b1; ex_addr = 5'd7; ex_data = 32'h2;
      q1_addr = 5'd7; q2_addr = 5'd0;
      #2;
      check_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // single write, accepted on first edge after reset release
      step(1'b1, 5'd5, 32'hAA, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd5, 5'd0);
      check("single_A3", 32'(A3), 32'd5);
      check("single_WD", WD, 32'hAA);
      check("single_RFWr", 32'(RFWr), 32'd1);
      idle(1'b0);
      check("single_drained", 32'(count), 32'd0);

      // dual push to the same register, bypass returns the younger ex value
      step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 1'b0, 1'b1, 5'd3, 5'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd3, 5'd3);
      check("dual_q1_data", q1_data, 32'h22);
      check("dual_count", 32'(count), 32'd2);
      idle(1'b0);
      idle(1'b0);
      idle(1'b0);

      // fill to DEPTH under hold, then drain with wrapping pointers
      step(1'b1, 5'd1, 32'hA1, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd2, 5'd9);
      step(1'b1, 5'd2, 32'hA2, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd2, 5'd9);
      step(1'b1, 5'd3, 32'hA3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd2, 5'd9);
      step(1'b1, 5'd4, 32'hA4, 1'b1, 5'd9, 32'hE9, 1'b0, 1'b1, 5'd4, 5'd9);
      step(1'b1, 5'd6, 32'hA6, 1'b1, 5'd9, 32'hE9, 1'b0, 1'b1, 5'd1, 5'd9);
      for (int i = 0; i < 5; i++) idle(1'b0);

      // zero-register request is accepted but never stored
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0, 5'd0, 5'd0);
      idle(1'b0);
      check("x0_count", 32'(count), 32'd0);

      // flush with a concurrent push
      step(1'b1, 5'd8, 32'h81, 1'b1, 5'd9, 32'h91, 1'b0, 1'b1, 5'd8, 5'd9);
      step(1'b1, 5'd10, 32'hB0, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 5'd8, 5'd9);
      check("flush_count", 32'(count), 32'd0);
      idle(1'b0);
      idle(1'b0);

      // asynchronous reset between edges with entries pending
      step(1'b1, 5'd11, 32'hC1, 1'b1, 5'd12, 32'hC2, 1'b0, 1'b1, 5'd11, 5'd12);
      step(1'b1, 5'd13, 32'hC3, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd11, 5'd13);
      q1_addr = 5'd11; q2_addr = 5'd13; hold = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      check_zero("async");
      mq.delete();
      @(negedge clk);
      rst = 1'b1;
      idle(1'b0);
      idle(1'b0);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)), $urandom,
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 5)), $urandom,
              ($urandom_range(0, 19) == 0), ($urandom_range(0, 2) == 0),
              5'($urandom_range(0, 5)), 5'($urandom_range(0, 5)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
